// File: rtl/sliding_window_agg.sv
// Sliding-window aggregation unit: event values accumulate into the head
// bucket, a period timer rotates the bucket ring, and a query returns the
// sum/max over all buckets one cycle later.
// Optional feature macro: SW_COUNT_EN adds per-bucket event counters and the
// out_count port (saturating total event count across the window).
module sliding_window_agg #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned NUM_BUCKETS  = 4,
    parameter int unsigned SLIDE_PERIOD = 250,
    parameter int unsigned AGG_MODE     = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              query,
    output logic                              out_valid,
    output logic [DATA_W-1:0]                 out_data,
    output logic                              slide,
    output logic [$clog2(NUM_BUCKETS)-1:0]    head_idx,
    output logic [$clog2(SLIDE_PERIOD)-1:0]   timer,
    output logic [NUM_BUCKETS*DATA_W-1:0]     buckets_flat
`ifdef SW_COUNT_EN
    ,
    output logic [31:0]                       out_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_BUCKETS);
    localparam int unsigned TMR_W = $clog2(SLIDE_PERIOD);
    localparam logic [DATA_W-1:0] IDENT =
        (AGG_MODE == 1) ? {1'b1, {(DATA_W-1){1'b0}}} : DATA_W'(0);

    logic [DATA_W-1:0] bucket_q [NUM_BUCKETS];
    logic [DATA_W-1:0] bucket_d [NUM_BUCKETS];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              slide_c;
    logic              event_c;
    logic              query_c;
    logic [DATA_W-1:0] agg_c;

    // Combine two values according to the aggregation mode.
    function automatic logic [DATA_W-1:0] agg2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        if (AGG_MODE == 1)
            return ($signed(a) > $signed(b)) ? a : b;
        else
            return a + b;
    endfunction

    // Next-state: timer, slide/rotation (applied before the event) and event update.
    always_comb begin
        slide_c = 1'b0;
        event_c = 1'b0;
        query_c = 1'b0;
        timer_d = timer_q;
        head_d  = head_q;
        for (int i = 0; i < NUM_BUCKETS; i++) bucket_d[i] = bucket_q[i];
        if (en) begin
            slide_c = (timer_q == TMR_W'(SLIDE_PERIOD - 1));
            event_c = in_valid;
            query_c = query;
            timer_d = slide_c ? TMR_W'(0) : timer_q + TMR_W'(1);
            if (slide_c) begin
                head_d = (head_q == IDX_W'(NUM_BUCKETS - 1)) ? IDX_W'(0) : head_q + IDX_W'(1);
                bucket_d[head_d] = IDENT;
            end
            if (event_c) bucket_d[head_d] = agg2(bucket_d[head_d], in_data);
        end
    end

    // Window reduction over the next-state buckets.
    always_comb begin
        agg_c = IDENT;
        for (int i = 0; i < NUM_BUCKETS; i++) agg_c = agg2(agg_c, bucket_d[i]);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BUCKETS; i++) bucket_q[i] <= IDENT;
            head_q    <= '0;
            timer_q   <= '0;
            slide     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_BUCKETS; i++) bucket_q[i] <= bucket_d[i];
            head_q    <= head_d;
            timer_q   <= timer_d;
            slide     <= slide_c;
            out_valid <= query_c;
            if (query_c) out_data <= agg_c;
        end
    end

    assign head_idx = head_q;
    assign timer    = timer_q;

    for (genvar g = 0; g < NUM_BUCKETS; g++) begin : g_flat
        assign buckets_flat[g*DATA_W +: DATA_W] = bucket_q[g];
    end

`ifdef SW_COUNT_EN
    localparam int unsigned CSUM_W = 33 + IDX_W;

    logic [31:0]       cnt_q [NUM_BUCKETS];
    logic [31:0]       cnt_d [NUM_BUCKETS];
    logic [CSUM_W-1:0] cnt_sum_c;
    logic [31:0]       cnt_tot_c;

    // Per-bucket saturating event counters, cleared with their bucket.
    always_comb begin
        for (int i = 0; i < NUM_BUCKETS; i++) cnt_d[i] = cnt_q[i];
        if (slide_c) cnt_d[head_d] = '0;
        if (event_c && (cnt_d[head_d] != 32'hFFFF_FFFF))
            cnt_d[head_d] = cnt_d[head_d] + 32'd1;
    end

    // Saturating total of the next-state counters.
    always_comb begin
        cnt_sum_c = '0;
        for (int i = 0; i < NUM_BUCKETS; i++) cnt_sum_c = cnt_sum_c + CSUM_W'(cnt_d[i]);
        cnt_tot_c = (cnt_sum_c > CSUM_W'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : cnt_sum_c[31:0];
    end

    // Counter state and registered count output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BUCKETS; i++) cnt_q[i] <= '0;
            out_count <= '0;
        end else begin
            for (int i = 0; i < NUM_BUCKETS; i++) cnt_q[i] <= cnt_d[i];
            if (query_c) out_count <= cnt_tot_c;
        end
    end
`endif

endmodule

// File: tb/tb_sliding_window_agg.sv
// Scoreboard bench for sliding_window_agg: a sum-mode instance (P=250) and a
// max-mode instance (P=8). Queries push expected results; a monitor pops on
// out_valid. Build with +define+SW_COUNT_EN to also check out_count.
module tb_sliding_window_agg;

    typedef struct packed {
        logic [63:0] d;
        logic [31:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        en_s = 0, iv_s = 0, q_s = 0;
    logic [63:0] id_s = '0;
    logic        ov_s, sl_s;
    logic [63:0] od_s;
    logic [1:0]  hd_s;
    logic [7:0]  tm_s;
    logic [255:0] bf_s;

    logic        en_m = 0, iv_m = 0, q_m = 0;
    logic [63:0] id_m = '0;
    logic        ov_m, sl_m;
    logic [63:0] od_m;
    logic [1:0]  hd_m;
    logic [2:0]  tm_m;
    logic [255:0] bf_m;
`ifdef SW_COUNT_EN
    logic [31:0] oc_s, oc_m;
`endif

    exp_t exp_s[$];
    exp_t exp_m[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sliding_window_agg #(.DATA_W(64), .NUM_BUCKETS(4), .SLIDE_PERIOD(250), .AGG_MODE(0)) u_sum (
        .clk(clk), .rst(rst), .en(en_s), .in_valid(iv_s), .in_data(id_s), .query(q_s),
        .out_valid(ov_s), .out_data(od_s), .slide(sl_s), .head_idx(hd_s), .timer(tm_s),
        .buckets_flat(bf_s)
`ifdef SW_COUNT_EN
        , .out_count(oc_s)
`endif
    );

    sliding_window_agg #(.DATA_W(64), .NUM_BUCKETS(4), .SLIDE_PERIOD(8), .AGG_MODE(1)) u_max (
        .clk(clk), .rst(rst), .en(en_m), .in_valid(iv_m), .in_data(id_m), .query(q_m),
        .out_valid(ov_m), .out_data(od_m), .slide(sl_m), .head_idx(hd_m), .timer(tm_m),
        .buckets_flat(bf_m)
`ifdef SW_COUNT_EN
        , .out_count(oc_m)
`endif
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every out_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (ov_s === 1'b1) begin
            if (exp_s.size() == 0) begin
                chk("sum_unexpected_valid", 256'(1), 256'(0));
            end else begin
                e = exp_s.pop_front();
                chk("sum_out_data", 256'(od_s), 256'(e.d));
`ifdef SW_COUNT_EN
                chk("sum_out_count", 256'(oc_s), 256'(e.c));
`endif
            end
        end
        if (ov_m === 1'b1) begin
            if (exp_m.size() == 0) begin
                chk("max_unexpected_valid", 256'(1), 256'(0));
            end else begin
                e = exp_m.pop_front();
                chk("max_out_data", 256'(od_m), 256'(e.d));
`ifdef SW_COUNT_EN
                chk("max_out_count", 256'(oc_m), 256'(e.c));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enabled sum-DUT edge with idle inputs.
    task automatic step_s();
        tick();
        cyc++;
    endtask

    task automatic goto_s(input int k);
        while (cyc < k) step_s();
    endtask

    task automatic event_s(input logic [63:0] v);
        iv_s = 1'b1; id_s = v;
        step_s();
        iv_s = 1'b0; id_s = '0;
    endtask

    task automatic query_s(input logic [63:0] d, input logic [31:0] c);
        exp_s.push_back('{d: d, c: c});
        q_s = 1'b1;
        step_s();
        q_s = 1'b0;
    endtask

    task automatic event_m(input logic [63:0] v);
        iv_m = 1'b1; id_m = v;
        tick();
        iv_m = 1'b0; id_m = '0;
    endtask

    task automatic query_m(input logic [63:0] d, input logic [31:0] c);
        exp_m.push_back('{d: d, c: c});
        q_m = 1'b1;
        tick();
        q_m = 1'b0;
    endtask

    initial begin
        // Reset held for 3 cycles.
        repeat (3) tick();
        chk("rst_out_valid", 256'(ov_s), 256'(0));
        chk("rst_out_data", 256'(od_s), 256'(0));
        chk("rst_slide", 256'(sl_s), 256'(0));
        chk("rst_head", 256'(hd_s), 256'(0));
        chk("rst_timer", 256'(tm_s), 256'(0));
        chk("rst_buckets", bf_s, 256'(0));
        chk("rst_max_buckets", bf_m, {4{64'h8000_0000_0000_0000}});
        rst = 1'b1;
        en_s = 1'b1;

        query_s(64'd0, 32'd0);                       // edge 1
        chk("q1_head", 256'(hd_s), 256'(0));
        chk("q1_buckets", bf_s, 256'(0));

        goto_s(9);    event_s(64'd1);                // edge 10
        goto_s(19);   event_s(64'd2);                // edge 20
        goto_s(29);   query_s(64'd3, 32'd2);         // edge 30
        goto_s(99);   event_s(64'd5);                // edge 100, b0=8
        goto_s(249);
        chk("pre_slide_timer", 256'(tm_s), 256'(249));
        chk("pre_slide_pulse", 256'(sl_s), 256'(0));
        step_s();                                    // edge 250: slide
        chk("slide1_pulse", 256'(sl_s), 256'(1));
        chk("slide1_head", 256'(hd_s), 256'(1));
        chk("slide1_timer", 256'(tm_s), 256'(0));
        step_s();
        chk("slide1_pulse_end", 256'(sl_s), 256'(0));

        goto_s(349);  event_s(64'd7);                // b1=7
        goto_s(599);  event_s(64'd9);                // b2=9
        goto_s(999);
        query_s(64'd16, 32'd2);                      // edge 1000: 4th slide, same-edge query
        chk("slide4_head", 256'(hd_s), 256'(0));
        chk("slide4_buckets", bf_s, {64'd0, 64'd9, 64'd7, 64'd0});
        query_s(64'd16, 32'd2);                      // back-to-back query

        goto_s(1099); event_s(64'd3);                // b0=3
        goto_s(1249);
        chk("edge_timer", 256'(tm_s), 256'(249));
        event_s(64'd4);                              // edge 1250: slide + event
        chk("edge_head", 256'(hd_s), 256'(1));
        chk("edge_buckets", bf_s, {64'd0, 64'd9, 64'd4, 64'd3});
        query_s(64'd16, 32'd3);                      // edge 1251

        // Freeze for 100 cycles with ignored events and a dropped query.
        goto_s(1300);
        chk("frz_timer_before", 256'(tm_s), 256'(50));
        en_s = 1'b0;
        for (int i = 0; i < 100; i++) begin
            iv_s = (i % 10 == 0);
            id_s = 64'd100;
            q_s  = (i == 50);
            tick();
            if (sl_s !== 1'b0) chk("frz_slide", 256'(sl_s), 256'(0));
        end
        iv_s = 1'b0; id_s = '0; q_s = 1'b0;
        chk("frz_timer_after", 256'(tm_s), 256'(50));
        chk("frz_buckets", bf_s, {64'd0, 64'd9, 64'd4, 64'd3});
        chk("frz_head", 256'(hd_s), 256'(1));
        en_s = 1'b1;
        goto_s(1499);
        chk("delayed_no_slide", 256'(sl_s), 256'(0));
        chk("delayed_head_pre", 256'(hd_s), 256'(1));
        step_s();                                    // slide delayed by 100 real cycles
        chk("delayed_slide", 256'(sl_s), 256'(1));
        chk("delayed_head", 256'(hd_s), 256'(2));
        query_s(64'd7, 32'd2);                       // b2 cleared
        event_s(64'h7FFF_FFFF_FFFF_FFFF);
        event_s(64'd2);                              // b2 wraps to -2^63+1
        query_s(64'h8000_0000_0000_0008, 32'd4);

        // Mid-window reset discards contents and the in-flight query.
        q_s = 1'b1;
        tick();
        q_s = 1'b0;
        rst = 1'b0;
        #2;
        chk("mrst_valid", 256'(ov_s), 256'(0));
        chk("mrst_buckets", bf_s, 256'(0));
        chk("mrst_head", 256'(hd_s), 256'(0));
        chk("mrst_timer", 256'(tm_s), 256'(0));
        chk("mrst_out_data", 256'(od_s), 256'(0));
        tick();
        tick();
        rst = 1'b1;
        en_s = 1'b0;

        // Max mode.
        en_m = 1'b1;
        event_m(-64'sd5);                            // m1
        event_m(-64'sd3);                            // m2
        query_m(64'hFFFF_FFFF_FFFF_FFFD, 32'd2);     // m3
        tick();                                      // m4
        chk("max_hold_valid", 256'(ov_m), 256'(0));
        chk("max_hold_data", 256'(od_m), 256'(64'hFFFF_FFFF_FFFF_FFFD));
        repeat (28) tick();                          // m5..m32, 4 slides
        chk("max_head_wrap", 256'(hd_m), 256'(0));
        query_m(64'h8000_0000_0000_0000, 32'd0);     // m33
        tick();
        tick();

        chk("sum_queue_drained", 256'(exp_s.size()), 256'(0));
        chk("max_queue_drained", 256'(exp_m.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sliding_window_agg.md
Name: sliding_window_agg

Overview:
- Parametrised sliding-window aggregation unit for the RTLola monitor datapath.
- Generalises the fixed 4-bucket sum window to N buckets, configurable width, slide period and aggregation mode (sum/max).
- Event-based input values are accumulated into the head bucket. An internal period timer rotates the bucket ring. On request, an aggregate over all buckets is returned one cycle later.
- Sits between the input event queue (pop side) and the output stream evaluators.

Parameters:
- DATA_W, 64, signed width of input values, buckets and aggregate.
- NUM_BUCKETS, 4, number of window buckets; >=2.
- SLIDE_PERIOD, 250, clock cycles per bucket slide; >=2.
- AGG_MODE, 0, 0 = sum (identity 0), 1 = max (identity most-negative DATA_W value).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  global enable; low freezes all state.
- in_valid  in  1  one-cycle event strobe.
- in_data  in  DATA_W  signed event value, sampled when in_valid=1.
- query  in  1  aggregate request strobe.
- out_valid  out  1  one-cycle pulse, aggregate ready.
- out_data  out  DATA_W  signed window aggregate.
- slide  out  1  one-cycle pulse on bucket rotation.
- head_idx  out  clog2(NUM_BUCKETS)  current head bucket index.
- timer  out  clog2(SLIDE_PERIOD)  slide timer value.
- buckets_flat  out  NUM_BUCKETS*DATA_W  debug dump; bucket i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (rst=0, async):
  - all buckets = identity; head_idx=0; timer=0.
  - out_valid=0, out_data=0, slide=0 (and out_count=0 when SW_COUNT_EN is defined).
  - Asserting rst mid-window discards all contents immediately; an in-flight query produces no out_valid.
- en=0:
  - no state changes; timer holds; in_valid and query are ignored (dropped, not deferred).
  - out_valid and slide forced 0 on the next edge.
- Timer:
  - increments each enabled cycle.
  - When timer==SLIDE_PERIOD-1 it wraps to 0 and a slide occurs on that same edge.
  - slide=1 during the following cycle.
- Slide:
  - head_idx advances by 1, wrapping NUM_BUCKETS-1 -> 0.
  - The new head bucket is overwritten with identity, discarding the oldest data.
- Event:
  - sum mode: head bucket += in_data, modulo 2^DATA_W (two's-complement wrap, no saturation).
  - max mode: head bucket = signed max(head bucket, in_data).
- Slide and event in the same cycle: the slide is applied first; in_data goes into the freshly cleared new head bucket, never into the evicted one.
- Query:
  - out_data is the reduction (same AGG_MODE) over all NUM_BUCKETS bucket values as they stand after this edge's slide/event updates.
  - Latency 1: query at edge k gives out_valid=1 and out_data during cycle k+1.
  - out_data holds its value until the next query; out_valid is a single-cycle pulse.
  - Back-to-back queries give back-to-back valid pulses.
- Reduction: combinational tree over next-state buckets, registered once. No multicycle paths.
- All outputs are registered except head_idx, timer and buckets_flat, which are direct state views.

Optional Feature:
- Macro SW_COUNT_EN.
- Defined:
  - adds per-bucket event counters, 32-bit saturating at 2^32-1.
  - adds output port out_count [31:0], the total event count across the window. Computed as a 32-bit sum of the bucket counters that saturates at 2^32-1.
  - out_count updates alongside out_data with the same latency and hold rules.
  - A counter is cleared with its bucket on slide; the same-cycle slide+event rule applies.
- Not defined: no counters and no out_count port; behaviour otherwise identical.

Test Plan (DATA_W=64, NUM_BUCKETS=4, SLIDE_PERIOD=250, AGG_MODE=0 unless stated):
- rst=0 for 3 cycles then rst=1, en=1, query -> out_valid next cycle, out_data=0, head_idx=0, all buckets 0.
- Events 1 and 2 at cycles 10 and 20, query at cycle 30 -> out_data=3; slide pulse at cycle 250; head_idx=1.
- Events 5 at cycle 100, 7 at cycle 350, 9 at cycle 600; query after the 4th slide (head_idx back to 0, bucket 0 cleared) -> out_data=16 (7+9).
- Event 4 on the exact cycle timer==249 -> value lands in bucket 1, not bucket 0; with bucket 0 previously 3, buckets_flat shows b0=3, b1=4.
- en=0 for 100 cycles mid-window with in_valid pulses -> timer frozen, no bucket change, no slide; the next slide is delayed by exactly 100 cycles.
- AGG_MODE=1: events -5 and -3 only, query -> out_data=-3; query after all buckets slide out -> out_data=-2^63; with SW_COUNT_EN defined, the same events give out_count=2 and then 0.
